// File: rtl/mamba_pkg.sv
// Shared Mamba datapath types and helpers: state-vector typedef and the
// word/frame geometry functions used by the packer.
package mamba_pkg;

  localparam int TILE_SIZE_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 16;

  typedef logic signed [DATA_WIDTH_DEF-1:0] elem_t;
  typedef elem_t [TILE_SIZE_DEF-1:0]        vec_t;

  // Vectors per packed output word.
  function automatic int calc_vpb(input int data_w, input int tile, input int dw);
    return data_w / (tile * dw);
  endfunction

  // Output words (beats) per frame.
  function automatic int calc_bpf(input int d, input int tile, input int vpb);
    return d / (tile * vpb);
  endfunction

endpackage

// File: rtl/state_vec_packer.sv
// Packs TILE_SIZE-element state vectors into DATA_W-bit AXI-Stream words and
// marks frame ends. Optional flush of a partial word: STATE_VEC_PACKER_FLUSH_EN.
module state_vec_packer
  import mamba_pkg::*;
#(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_W     = 256,
  parameter int D          = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0] in_vec,
  output logic                            m_axis_TVALID,
  input  logic                            m_axis_TREADY,
  output logic [DATA_W-1:0]               m_axis_TDATA,
  output logic                            m_axis_TLAST,
`ifdef STATE_VEC_PACKER_FLUSH_EN
  input  logic                            flush,
`endif
  output logic                            frame_done
);

  localparam int VEC_W  = TILE_SIZE * DATA_WIDTH;
  localparam int VPB    = calc_vpb(DATA_W, TILE_SIZE, DATA_WIDTH);
  localparam int BPF    = calc_bpf(D, TILE_SIZE, VPB);
  localparam int LANE_W = (VPB > 1) ? $clog2(VPB) : 1;
  localparam int BEAT_W = (BPF > 1) ? $clog2(BPF) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VPB - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPF - 1);

  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              out_fire, out_stall, in_ready_c, in_fire, load;
  logic [DATA_W-1:0] word_next;
`ifdef STATE_VEC_PACKER_FLUSH_EN
  logic              flush_pend_q, flush_pend_d;
  logic              flush_req, flush_load;
`endif

  always_comb begin
    out_fire  = out_valid_q && m_axis_TREADY;
    out_stall = out_valid_q && !m_axis_TREADY;
`ifdef STATE_VEC_PACKER_FLUSH_EN
    flush_req  = flush || flush_pend_q;
    in_ready_c = !(out_stall && ((lane_cnt_q == LAST_LANE) || flush_req));
`else
    in_ready_c = !(out_stall && (lane_cnt_q == LAST_LANE));
`endif
    in_fire = in_valid && in_ready_c;

    // A new word starts from zero so unfilled lanes never carry stale data.
    word_next = (lane_cnt_q == '0) ? '0 : asm_q;
    if (in_fire) word_next[int'(lane_cnt_q)*VEC_W +: VEC_W] = in_vec;

    lane_cnt_d  = lane_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    load        = 1'b0;

    // The beat counter restarts after any last word, including a flushed one.
    if (out_fire) begin
      out_valid_d = 1'b0;
      beat_cnt_d  = out_last_q ? '0 : beat_cnt_q + 1'b1;
    end

    if (in_fire) begin
      if (lane_cnt_q == LAST_LANE) begin
        load       = 1'b1;
        lane_cnt_d = '0;
        asm_d      = '0;
      end else begin
        asm_d      = word_next;
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
    end

`ifdef STATE_VEC_PACKER_FLUSH_EN
    flush_pend_d = 1'b0;
    flush_load   = 1'b0;
    if (flush_req) begin
      if (out_stall) begin
        flush_pend_d = 1'b1;
      end else if (in_fire || (lane_cnt_q != '0)) begin
        load       = 1'b1;
        flush_load = 1'b1;
        lane_cnt_d = '0;
        asm_d      = '0;
      end else begin
        beat_cnt_d = '0;
      end
    end
`endif

    // beat_cnt_d is the index of the word being loaded: the previous word has
    // either just left or the register was already empty.
    if (load) begin
      out_data_d  = word_next;
      out_valid_d = 1'b1;
      out_last_d  = (beat_cnt_d == LAST_BEAT);
`ifdef STATE_VEC_PACKER_FLUSH_EN
      if (flush_load) out_last_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      asm_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
`ifdef STATE_VEC_PACKER_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      asm_q        <= asm_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
`ifdef STATE_VEC_PACKER_FLUSH_EN
      flush_pend_q <= flush_pend_d;
`endif
    end
  end

  assign in_ready      = in_ready_c;
  assign m_axis_TVALID = out_valid_q;
  assign m_axis_TDATA  = out_data_q;
  assign m_axis_TLAST  = out_last_q;
  assign frame_done    = out_fire && out_last_q;

endmodule

// File: tb/tb_state_vec_packer.sv
// Self-checking bench for state_vec_packer: queue-based reference model plus
// directed literal checks; flush cases run when STATE_VEC_PACKER_FLUSH_EN is set.
module tb_state_vec_packer;
  import mamba_pkg::*;

  localparam int VW  = 64;
  localparam int VPB = 4;
  localparam int BPF = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_vec;
  logic          m_axis_TVALID;
  logic          m_axis_TREADY;
  logic [255:0]  m_axis_TDATA;
  logic          m_axis_TLAST;
  logic          frame_done;
`ifdef STATE_VEC_PACKER_FLUSH_EN
  logic          flush;
`endif

  state_vec_packer #(.TILE_SIZE(4), .DATA_WIDTH(16), .DATA_W(256), .D(256)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_vec        (in_vec),
    .m_axis_TVALID (m_axis_TVALID),
    .m_axis_TREADY (m_axis_TREADY),
    .m_axis_TDATA  (m_axis_TDATA),
    .m_axis_TLAST  (m_axis_TLAST),
`ifdef STATE_VEC_PACKER_FLUSH_EN
    .flush         (flush),
`endif
    .frame_done    (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: words pending on the output, partial word, words per frame.
  logic [255:0] qd[$];
  bit           ql[$];
  logic [255:0] part;
  int           part_n;
  int           wcnt;
  bit           chk_en;
  int           nwords;
  int           fd_cnt;
  logic [255:0] first_word;
  logic [255:0] last_word;
  bit           last_tlast;
  int           vidx;

  task automatic model_clear();
    qd.delete();
    ql.delete();
    part   = '0;
    part_n = 0;
    wcnt   = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_tv;
      bit ofire;
      exp_tv = (qd.size() != 0);
      chk("tvalid", m_axis_TVALID, exp_tv);
      if (exp_tv) begin
        chk("tdata", m_axis_TDATA, qd[0]);
        chk("tlast", m_axis_TLAST, ql[0]);
      end
      chk("in_ready", in_ready, !((part_n == VPB-1) && exp_tv && !m_axis_TREADY));
      ofire = m_axis_TVALID && m_axis_TREADY;
      chk("frame_done", frame_done, ofire && exp_tv && ql[0]);
      if (frame_done) fd_cnt++;
      if (ofire && exp_tv) begin
        if (nwords == 0) first_word = qd[0];
        last_word  = qd[0];
        last_tlast = ql[0];
        nwords++;
        void'(qd.pop_front());
        void'(ql.pop_front());
      end
      if (in_valid && in_ready) begin
        part[part_n*VW +: VW] = in_vec;
        part_n++;
        if (part_n == VPB) begin
          qd.push_back(part);
          ql.push_back(wcnt == BPF-1);
          wcnt   = (wcnt + 1) % BPF;
          part   = '0;
          part_n = 0;
        end
      end
`ifdef STATE_VEC_PACKER_FLUSH_EN
      if (flush) begin
        if (part_n > 0) begin
          qd.push_back(part);
          ql.push_back(1'b1);
          part   = '0;
          part_n = 0;
        end
        wcnt = 0;
      end
`endif
    end
  end

  function automatic logic [VW-1:0] mk_vec(input int n);
    vec_t v;
    for (int i = 0; i < 4; i++) v[i] = 16'(4*n + i);
    return v;
  endfunction

  task automatic drive(input int nvec, input int pv, input int pr, input bit seq);
    int sent = 0;
    int cyc  = 0;
    logic [VW-1:0] cur;
    cur = seq ? mk_vec(vidx) : {$urandom(), $urandom()};
    while (sent < nvec && cyc < 20000) begin
      in_valid      = ($urandom_range(99) < pv);
      in_vec        = cur;
      m_axis_TREADY = ($urandom_range(99) < pr);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        vidx++;
        cur = seq ? mk_vec(vidx) : {$urandom(), $urandom()};
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("drive_budget", sent, nvec);
  endtask

  task automatic send_one(input logic [VW-1:0] v);
    bit got = 0;
    in_valid      = 1'b1;
    in_vec        = v;
    m_axis_TREADY = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_accept", got, 1'b1);
  endtask

  task automatic drain();
    m_axis_TREADY = 1'b1;
    for (int c = 0; c < 100 && qd.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("drain", qd.size() == 0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int fd0;
    int nw0;
    vec_t nv;

    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_vec        = '0;
    m_axis_TREADY = 1'b0;
    chk_en        = 1'b0;
    vidx          = 0;
    nwords        = 0;
    fd_cnt        = 0;
    first_word    = '0;
    last_word     = '0;
    last_tlast    = 1'b0;
`ifdef STATE_VEC_PACKER_FLUSH_EN
    flush         = 1'b0;
`endif
    model_clear();
    #1;
    chk("rst_tvalid", m_axis_TVALID, 1'b0);
    chk("rst_tdata", m_axis_TDATA, '0);
    chk("rst_tlast", m_axis_TLAST, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Continuous stream, sink always ready: one frame of 16 words.
    drive(64, 100, 100, 1'b1);
    drain();
    chk("stream_words", nwords, 16);
    chk("stream_frames", fd_cnt, 1);
    chk("stream_word0", first_word,
        256'h000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000);
    chk("stream_tlast_last", last_tlast, 1'b1);

    // Backpressure: word0 completes, three more vectors fit, then in_ready drops.
    acc           = 0;
    nwords        = 0;
    m_axis_TREADY = 1'b0;
    in_valid      = 1'b1;
    in_vec        = mk_vec(vidx);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc++;
        vidx++;
      end
      @(posedge clk); #1;
      in_vec = mk_vec(vidx);
    end
    in_valid = 1'b0;
    chk("stall_accepted", acc, 7);
    chk("stall_in_ready", in_ready, 1'b0);
    drive(57, 100, 100, 1'b1);
    drain();
    chk("stall_words", nwords, 16);
    chk("stall_frames", fd_cnt, 2);

    // Random valid/ready over three frames.
    nwords = 0;
    drive(192, 50, 50, 1'b0);
    drain();
    chk("rand_words", nwords, 48);
    chk("rand_frames", fd_cnt, 5);

    // Negative elements land bit-exact in lane 0.
    nv[0] = -16'sd1;
    nv[1] = 16'sh8000;
    nv[2] = 16'sd32767;
    nv[3] = 16'sd0;
    send_one(nv);
    for (int k = 1; k < 4; k++) send_one(mk_vec(k));
    drain();
    chk("neg_lane0", last_word[63:0], 64'h0000_7fff_8000_ffff);

    // Reset in the middle of beat 5, after two vectors of it.
    drive(18, 100, 100, 1'b1);
    drain();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_tvalid", m_axis_TVALID, 1'b0);
    chk("mid_rst_tdata", m_axis_TDATA, '0);
    chk("mid_rst_tlast", m_axis_TLAST, 1'b0);
    chk("mid_rst_frame_done", frame_done, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    model_clear();
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    nwords = 0;
    fd0    = fd_cnt;
    drive(4, 100, 100, 1'b1);
    drain();
    chk("post_rst_words", nwords, 1);
    chk("post_rst_tlast", last_tlast, 1'b0);
    chk("post_rst_frames", fd_cnt, fd0);

`ifdef STATE_VEC_PACKER_FLUSH_EN
    // Flush after two vectors: zero-padded last word, then a new frame.
    send_one(mk_vec(100));
    send_one(mk_vec(101));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drain();
    chk("flush_upper_zero", last_word[255:128], 128'h0);
    chk("flush_lower", last_word[127:0], {mk_vec(101), mk_vec(100)});
    chk("flush_tlast", last_tlast, 1'b1);
    nw0 = nwords;
    drive(4, 100, 100, 1'b1);
    drain();
    chk("flush_next_words", nwords, nw0 + 1);
    chk("flush_next_tlast", last_tlast, 1'b0);

    // Vector accepted with the flush pulse is part of the flushed word.
    send_one(mk_vec(200));
    flush = 1'b1;
    send_one(mk_vec(201));
    flush = 1'b0;
    drain();
    chk("flush_same_cycle", last_word, {128'h0, mk_vec(201), mk_vec(200)});
    chk("flush_same_tlast", last_tlast, 1'b1);
`else
    nw0 = nwords;
    drive(8, 100, 100, 1'b1);
    drain();
    chk("tail_words", nwords, nw0 + 2);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
